pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipelined CPU (IF/ID/EX/MEM/WB). It watches register usage in ID and EX, and the branch outcome resolved in EX. From these it drives PC/IF-ID enables, bubble/flush controls for the IF/ID and ID/EX registers, and EX-stage operand forwarding selects. It holds its own EX-stage shadow of source-register numbers, a branch-flush state machine, and saturating stall/flush event counters.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and operand forwarding control for a 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwr,
  input  logic [4:0]       wb_rw,
  input  logic             wb_regwr,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] LSTALL = 2'b01;
  localparam logic [1:0] BFLUSH = 2'b10;
  localparam logic [1:0] FE     = 2'(FLUSH_EXTRA);

  logic       lu;
  logic [1:0] next_state;
  logic [1:0] bf_cnt;
  logic [1:0] next_bf;
  logic       stall_evt;
  logic       flush_evt;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;

  assign lu = ex_regwr & ex_memtoreg & (ex_rw != 5'd0) &
              ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    next_state = RUN;
    next_bf    = bf_cnt;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
      if (FE != 2'd0) begin
        next_state = BFLUSH;
        next_bf    = FE;
      end
    end else if (state == BFLUSH) begin
      // ID only holds a squashed NOP here, so a load-use match is meaningless
      ifid_flush = 1'b1;
      next_bf    = (bf_cnt == 2'd0) ? 2'd0 : bf_cnt - 2'd1;
      next_state = (bf_cnt <= 2'd1) ? RUN : BFLUSH;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_evt  = 1'b1;
      next_state = LSTALL;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      bf_cnt    <= 2'd0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= next_state;
      bf_cnt <= next_bf;
      if (idex_flush) begin
        ex_rs <= 5'd0;
        ex_rt <= 5'd0;
      end else if (ifid_en) begin
        ex_rs <= id_rs;
        ex_rt <= id_uses_rt ? id_rt : 5'd0;
      end
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // MEM result is newer than WB, so it takes priority
  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == ex_rs))   fwd_a = 2'b01;
    else if (wb_regwr && (wb_rw != 5'd0) && (wb_rw == ex_rs)) fwd_a = 2'b10;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == ex_rt))   fwd_b = 2'b01;
    else if (wb_regwr && (wb_rw != 5'd0) && (wb_rw == ex_rt)) fwd_b = 2'b10;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rw, mem_rw, wb_rw;
  logic          id_uses_rt, ex_regwr, ex_memtoreg, mem_regwr, wb_regwr, ex_branch_taken;
  logic          pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t sb[$];

  pipe_hazard_ctrl #(.FLUSH_EXTRA(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_rw(mem_rw), .mem_regwr(mem_regwr),
    .wb_rw(wb_rw), .wb_regwr(wb_regwr),
    .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses);
    id_rs = rs; id_rt = rt; id_uses_rt = uses;
  endtask

  task automatic set_ex(input logic [4:0] rw, input logic rw_en, input logic ld, input logic br);
    ex_rw = rw; ex_regwr = rw_en; ex_memtoreg = ld; ex_branch_taken = br;
  endtask

  task automatic set_mw(input logic [4:0] mrw, input logic men, input logic [4:0] wrw, input logic wen);
    mem_rw = mrw; mem_regwr = men; wb_rw = wrw; wb_regwr = wen;
  endtask

  // called just after a rising edge: queue expectation, sample mid-cycle, then let the falling edge commit
  task automatic cyc(input string tag, input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    exp_t g;
    e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.st = st; e.sc = 4'(sc); e.fc = 4'(fc);
    sb.push_back(e);
    #2;
    g = sb.pop_front();
    chk({g.tag, ".ctl"},   16'({pc_en, ifid_en, ifid_flush, idex_flush}), 16'(g.ctl));
    chk({g.tag, ".fwd_a"}, 16'(fwd_a), 16'(g.fa));
    chk({g.tag, ".fwd_b"}, 16'(fwd_b), 16'(g.fb));
    chk({g.tag, ".state"}, 16'(state), 16'(g.st));
    chk({g.tag, ".stall"}, 16'(stall_cnt), 16'(g.sc));
    chk({g.tag, ".flush"}, 16'(flush_cnt), 16'(g.fc));
    @(negedge clk);
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0); set_ex(0, 0, 0, 0); set_mw(0, 0, 0, 0);
    @(posedge clk);
    cyc("reset",     4'b0011, 2'b00, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    cyc("idle",      4'b1100, 2'b00, 2'b00, 2'b00, 0, 0);
    set_ex(0, 1, 1, 0);
    cyc("rw0",       4'b1100, 2'b00, 2'b00, 2'b00, 0, 0);
    set_ex(2, 1, 1, 0); set_id(3, 2, 0);
    cyc("rt_unused", 4'b1100, 2'b00, 2'b00, 2'b00, 0, 0);
    set_id(2, 7, 1);
    cyc("lu",        4'b0001, 2'b00, 2'b00, 2'b00, 0, 0);
    set_ex(0, 0, 0, 0); set_mw(2, 1, 0, 0);
    cyc("lstall",    4'b1100, 2'b00, 2'b00, 2'b01, 1, 0);
    set_id(5, 5, 1); set_mw(0, 0, 2, 1);
    cyc("fwd_wb",    4'b1100, 2'b10, 2'b00, 2'b00, 1, 0);
    set_mw(5, 1, 5, 1);
    cyc("fwd_pri",   4'b1100, 2'b01, 2'b01, 2'b00, 1, 0);
    set_id(0, 0, 1); set_mw(5, 0, 5, 1);
    cyc("fwd_drop",  4'b1100, 2'b10, 2'b10, 2'b00, 1, 0);
    set_id(4, 6, 0); set_mw(0, 1, 0, 1);
    cyc("fwd_r0",    4'b1100, 2'b00, 2'b00, 2'b00, 1, 0);
    set_id(0, 0, 0); set_mw(6, 1, 4, 1);
    cyc("fwd_nort",  4'b1100, 2'b10, 2'b00, 2'b00, 1, 0);
    set_mw(0, 0, 0, 0); set_ex(3, 1, 1, 1); set_id(3, 0, 0);
    cyc("br_lu",     4'b1111, 2'b00, 2'b00, 2'b00, 1, 0);
    set_ex(3, 1, 1, 0);
    cyc("bflush",    4'b1110, 2'b00, 2'b00, 2'b10, 1, 1);
    set_ex(0, 0, 0, 0);
    cyc("post_br",   4'b1100, 2'b00, 2'b00, 2'b00, 1, 1);
    set_ex(3, 1, 1, 0);
    cyc("b2b_1",     4'b0001, 2'b00, 2'b00, 2'b00, 1, 1);
    cyc("b2b_2",     4'b0001, 2'b00, 2'b00, 2'b01, 2, 1);
    set_ex(0, 0, 0, 0);
    cyc("b2b_end",   4'b1100, 2'b00, 2'b00, 2'b01, 3, 1);
    cyc("b2b_run",   4'b1100, 2'b00, 2'b00, 2'b00, 3, 1);
    set_ex(3, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat%0d", i), 4'b0001, 2'b00, 2'b00, (i == 0) ? 2'b00 : 2'b01,
          (3 + i > 15) ? 15 : 3 + i, 1);
    end
    set_ex(0, 0, 0, 0);
    cyc("sat_end",   4'b1100, 2'b00, 2'b00, 2'b01, 15, 1);
    cyc("sat_run",   4'b1100, 2'b00, 2'b00, 2'b00, 15, 1);
    set_ex(0, 0, 0, 1);
    cyc("br2",       4'b1111, 2'b00, 2'b00, 2'b00, 15, 1);
    set_ex(0, 0, 0, 0);
    rst_n = 1'b0;
    cyc("rst_mid",   4'b0011, 2'b00, 2'b00, 2'b00, 0, 0);
    rst_n = 1'b1;
    cyc("rel",       4'b1100, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("rel2",      4'b1100, 2'b00, 2'b00, 2'b00, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
